// File: rtl/cdb_pkg.sv
// Shared CDB types and constants: packet layout, bus count and FU port indices.
// No logic; widths here are the defaults the arbiter is built with.
// Imported by the arbiter, its picker and anything that consumes CDB packets.
package cdb_pkg;

    localparam int NUM_CDB      = 2;
    localparam int CDB_XLEN     = 64;
    localparam int CDB_PRF_SIZE = 64;
    localparam int CDB_ROB_SIZE = 32;
    localparam int CDB_TAG_W    = $clog2(CDB_PRF_SIZE);
    localparam int CDB_ROB_W    = $clog2(CDB_ROB_SIZE);

    // Functional-unit result port indices
    localparam int FU_ALU0 = 0;
    localparam int FU_ALU1 = 1;
    localparam int FU_MULT = 2;
    localparam int FU_MEM  = 3;

    typedef struct packed {
        logic                 valid;
        logic [CDB_TAG_W-1:0] tag;
        logic [CDB_ROB_W-1:0] rob_idx;
        logic [CDB_XLEN-1:0]  data;
    } cdb_packet_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick2.sv
// Two-grant round-robin picker: first two requesters scanning upward from ptr.
// Purely combinational, zero latency.
// No backpressure of its own; the caller decides what a grant means.
module rr_pick2 #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt0,
    output logic [N-1:0]  o_gnt1,
    output logic [PW-1:0] o_last
);

    int   w_idx;
    logic w_found0;
    logic w_found1;

    // Walk the request vector from i_ptr with wrap; the last grant found sets o_last
    always_comb begin
        o_gnt0   = '0;
        o_gnt1   = '0;
        o_last   = i_ptr;
        w_found0 = 1'b0;
        w_found1 = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (i_req[w_idx]) begin
                if (!w_found0) begin
                    o_gnt0[w_idx] = 1'b1;
                    w_found0      = 1'b1;
                    o_last        = PW'(w_idx);
                end else if (!w_found1) begin
                    o_gnt1[w_idx] = 1'b1;
                    w_found1      = 1'b1;
                    o_last        = PW'(w_idx);
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants up to two FU results per cycle onto registered CDB1/CDB2.
// Latency: granted result visible on its bus 1 cycle after the ack.
// Backpressure: an un-acked FU holds its result and sees fu_available=0.
// Optional CDB_AGE_PRIORITY_EN: oldest-first by ROB age instead of round-robin.
module cdb_arbiter import cdb_pkg::*; #(
    parameter int NUM_FU   = 4,
    parameter int PRF_SIZE = CDB_PRF_SIZE,
    parameter int ROB_SIZE = CDB_ROB_SIZE,
    localparam int TAG_W   = $clog2(PRF_SIZE),
    localparam int RW      = $clog2(ROB_SIZE),
    localparam int PW      = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_FU-1:0]     fu_result_valid,
    input  logic [NUM_FU*64-1:0]  fu_result_data,
    input  logic [NUM_FU*TAG_W-1:0] fu_result_tag,
    input  logic [NUM_FU*RW-1:0]  fu_result_rob_idx,
    input  logic                  branch_recovery,
`ifdef CDB_AGE_PRIORITY_EN
    input  logic [RW-1:0]         rob_head,
`endif
    output logic [NUM_FU-1:0]     fu_result_ack,
    output logic [NUM_FU-1:0]     fu_available,
    output logic                  cdb1_valid,
    output logic [TAG_W-1:0]      cdb1_tag,
    output logic [63:0]           cdb1_in,
    output logic [RW-1:0]         cdb1_rob_idx,
    output logic                  cdb2_valid,
    output logic [TAG_W-1:0]      cdb2_tag,
    output logic [63:0]           cdb2_in,
    output logic [RW-1:0]         cdb2_rob_idx
);

    // Packet fields follow the package widths; PRF_SIZE/ROB_SIZE should match them.
    cdb_packet_t       r_cdb1, r_cdb2;
    cdb_packet_t       w_cdb1_nxt, w_cdb2_nxt;
    logic [PW-1:0]     r_rr_ptr;
    logic [NUM_FU-1:0] w_gnt0, w_gnt1;
    logic [PW-1:0]     w_idx0, w_idx1;
    logic              w_any0, w_any1;

`ifdef CDB_AGE_PRIORITY_EN
    logic [RW-1:0] w_age [NUM_FU];
    logic [RW-1:0] w_best;
    logic          w_found;
    int            w_sel0, w_sel1;

    // Age relative to the ROB head; the natural RW-bit wrap gives the modulo
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            w_age[i] = fu_result_rob_idx[i*RW +: RW] - rob_head;
        end
    end

    // Two oldest requesters; strict less-than keeps ties on the lower FU index
    always_comb begin
        w_gnt0  = '0;
        w_gnt1  = '0;
        w_best  = '0;
        w_found = 1'b0;
        w_sel0  = 0;
        w_sel1  = 0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (fu_result_valid[i] && (!w_found || w_age[i] < w_best)) begin
                w_found = 1'b1;
                w_best  = w_age[i];
                w_sel0  = i;
            end
        end
        w_gnt0[w_sel0] = w_found;
        w_found = 1'b0;
        w_best  = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (fu_result_valid[i] && !w_gnt0[i] && (!w_found || w_age[i] < w_best)) begin
                w_found = 1'b1;
                w_best  = w_age[i];
                w_sel1  = i;
            end
        end
        w_gnt1[w_sel1] = w_found;
    end

    // Pointer has no meaning under age priority; keep it parked at zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_rr_ptr <= '0;
        else        r_rr_ptr <= '0;
    end
`else
    logic [PW-1:0] w_last;
    logic [PW-1:0] w_ptr_nxt;

    rr_pick2 #(.N(NUM_FU), .PW(PW)) u_pick (
        .i_req  (fu_result_valid),
        .i_ptr  (r_rr_ptr),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1),
        .o_last (w_last)
    );

    assign w_ptr_nxt = (w_last == PW'(NUM_FU - 1)) ? '0 : w_last + 1'b1;

    // Advance past the last granted FU; recovery and idle cycles leave it alone
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                           r_rr_ptr <= '0;
        else if (!branch_recovery && w_any0)  r_rr_ptr <= w_ptr_nxt;
    end
`endif

    assign w_any0 = |w_gnt0;
    assign w_any1 = |w_gnt1;

    // One-hot grants to indices for the result muxes
    always_comb begin
        w_idx0 = '0;
        w_idx1 = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_gnt0[i]) w_idx0 = PW'(i);
            if (w_gnt1[i]) w_idx1 = PW'(i);
        end
    end

    // Recovery drains every valid FU; acks are held low while in reset
    assign fu_result_ack = !reset          ? '0 :
                           branch_recovery ? fu_result_valid :
                                             (w_gnt0 | w_gnt1);
    assign fu_available  = ~fu_result_valid | fu_result_ack;

    // Next bus contents: first grant to CDB1, second to CDB2, zeros when idle or squashed
    always_comb begin
        w_cdb1_nxt = '0;
        w_cdb2_nxt = '0;
        if (!branch_recovery && w_any0) begin
            w_cdb1_nxt.valid   = 1'b1;
            w_cdb1_nxt.tag     = fu_result_tag[w_idx0*TAG_W +: TAG_W];
            w_cdb1_nxt.rob_idx = fu_result_rob_idx[w_idx0*RW +: RW];
            w_cdb1_nxt.data    = fu_result_data[w_idx0*64 +: 64];
        end
        if (!branch_recovery && w_any1) begin
            w_cdb2_nxt.valid   = 1'b1;
            w_cdb2_nxt.tag     = fu_result_tag[w_idx1*TAG_W +: TAG_W];
            w_cdb2_nxt.rob_idx = fu_result_rob_idx[w_idx1*RW +: RW];
            w_cdb2_nxt.data    = fu_result_data[w_idx1*64 +: 64];
        end
    end

    // Registered broadcast stage, cleared asynchronously by reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cdb1 <= '0;
            r_cdb2 <= '0;
        end else begin
            r_cdb1 <= w_cdb1_nxt;
            r_cdb2 <= w_cdb2_nxt;
        end
    end

    assign cdb1_valid   = r_cdb1.valid;
    assign cdb1_tag     = r_cdb1.tag;
    assign cdb1_in      = r_cdb1.data;
    assign cdb1_rob_idx = r_cdb1.rob_idx;
    assign cdb2_valid   = r_cdb2.valid;
    assign cdb2_tag     = r_cdb2.tag;
    assign cdb2_in      = r_cdb2.data;
    assign cdb2_rob_idx = r_cdb2.rob_idx;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expected grants and bus contents.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1-2 units later.
// Build with CDB_AGE_PRIORITY_EN defined to exercise the age-priority vectors instead.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic         clock;
    logic         reset;
    logic [3:0]   fv;
    logic [255:0] fd;
    logic [23:0]  ft;
    logic [19:0]  fr;
    logic         br;
    logic [4:0]   head;
    logic [3:0]   ack, avail;
    logic         c1v, c2v;
    logic [5:0]   c1t, c2t;
    logic [63:0]  c1d, c2d;
    logic [4:0]   c1r, c2r;

    int total = 0;
    int bad   = 0;

    cdb_arbiter dut (
        .clock             (clock),
        .reset             (reset),
        .fu_result_valid   (fv),
        .fu_result_data    (fd),
        .fu_result_tag     (ft),
        .fu_result_rob_idx (fr),
        .branch_recovery   (br),
`ifdef CDB_AGE_PRIORITY_EN
        .rob_head          (head),
`endif
        .fu_result_ack     (ack),
        .fu_available      (avail),
        .cdb1_valid        (c1v),
        .cdb1_tag          (c1t),
        .cdb1_in           (c1d),
        .cdb1_rob_idx      (c1r),
        .cdb2_valid        (c2v),
        .cdb2_tag          (c2t),
        .cdb2_in           (c2d),
        .cdb2_rob_idx      (c2r)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Watchdog: the directed sequence is short, so anything this long is a hang
    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "bench timeout");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input int i, input logic v, input logic [5:0] t,
                       input logic [63:0] d, input logic [4:0] r);
        fv[i]         = v;
        ft[i*6 +: 6]  = t;
        fd[i*64 +: 64] = d;
        fr[i*5 +: 5]  = r;
    endtask

    // Advance one clock and land 1 unit past the rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        br    = 1'b0;
        head  = '0;
        fv = '0; fd = '0; ft = '0; fr = '0;
        for (int i = 0; i < 4; i++) put(i, 1'b1, 6'(8'h10 + i), 64'(100 + i), 5'(i));
        tick();
        tick();
        check_val("rst_cdb1_valid", 64'(c1v), 64'd0);
        check_val("rst_cdb2_valid", 64'(c2v), 64'd0);
        check_val("rst_cdb1_tag",   64'(c1t), 64'd0);
        check_val("rst_ack",        64'(ack), 64'd0);

        reset = 1'b1;
        #1;
`ifndef CDB_AGE_PRIORITY_EN
        // All four held: pairs {0,1},{2,3},{0,1},{2,3}
        check_val("rr_c1_ack", 64'(ack), 64'b0011);
        tick();
        check_val("rr_c1_cdb1_tag", 64'(c1t), 64'h10);
        check_val("rr_c1_cdb2_tag", 64'(c2t), 64'h11);
        check_val("rr_c1_cdb1_dat", c1d, 64'd100);
        check_val("rr_c1_valids",   64'({c1v, c2v}), 64'b11);
        check_val("rr_c2_ack", 64'(ack), 64'b1100);
        tick();
        check_val("rr_c2_cdb1_tag", 64'(c1t), 64'h12);
        check_val("rr_c2_cdb2_tag", 64'(c2t), 64'h13);
        check_val("rr_c2_cdb2_rob", 64'(c2r), 64'd3);
        check_val("rr_c3_ack", 64'(ack), 64'b0011);
        tick();
        check_val("rr_c3_cdb1_tag", 64'(c1t), 64'h10);
        check_val("rr_c4_ack", 64'(ack), 64'b1100);
        tick();
        check_val("rr_c4_cdb1_tag", 64'(c1t), 64'h12);
        check_val("rr_c4_cdb2_tag", 64'(c2t), 64'h13);

        // Only MULT valid; pointer is back at 0
        fv = '0;
        put(FU_MULT, 1'b1, 6'h01, 64'd832, 5'd0);
        #1;
        check_val("mult_ack",   64'(ack), 64'b0100);
        check_val("mult_avail", 64'(avail[FU_MULT]), 64'd1);
        tick();
        check_val("mult_cdb1", {c1v, c1t, c1r, 52'd0}, {1'b1, 6'h01, 5'd0, 52'd0});
        check_val("mult_cdb1_dat", c1d, 64'd832);
        check_val("mult_cdb2_v",   64'(c2v), 64'd0);
        check_val("mult_cdb2_tag", 64'(c2t), 64'd0);

        // Idle cycle: nothing on either bus
        fv = '0;
        #1;
        check_val("idle_ack", 64'(ack), 64'd0);
        tick();
        check_val("idle_valids", 64'({c1v, c2v}), 64'b00);

        // Pointer now 3: ALU0, MULT, MEM valid -> MEM then ALU0, MULT waits
        put(FU_ALU0, 1'b1, 6'h20, 64'd7,  5'd4);
        put(FU_MULT, 1'b1, 6'h22, 64'd9,  5'd5);
        put(FU_MEM,  1'b1, 6'h23, 64'd11, 5'd6);
        #1;
        check_val("wait_ack",   64'(ack), 64'b1001);
        check_val("wait_avail", 64'(avail), 64'b1011);
        tick();
        check_val("wait_cdb1_tag", 64'(c1t), 64'h23);
        check_val("wait_cdb2_tag", 64'(c2t), 64'h20);
        put(FU_ALU0, 1'b0, 6'h00, 64'd0, 5'd0);
        put(FU_MEM,  1'b1, 6'h33, 64'd12, 5'd7);
        #1;
        check_val("late_ack",   64'(ack), 64'b1100);
        check_val("late_avail", 64'(avail[FU_MULT]), 64'd1);
        tick();
        check_val("late_cdb1_tag", 64'(c1t), 64'h22);
        check_val("late_cdb2_tag", 64'(c2t), 64'h33);
        check_val("late_cdb2_dat", c2d, 64'd12);

        // Branch recovery with three valids, pointer 0
        fv = '0;
        put(0, 1'b1, 6'h01, 64'd1, 5'd1);
        put(1, 1'b1, 6'h02, 64'd2, 5'd2);
        put(2, 1'b1, 6'h03, 64'd3, 5'd3);
        br = 1'b1;
        #1;
        check_val("br_ack", 64'(ack), 64'b0111);
        tick();
        check_val("br_valids", 64'({c1v, c2v}), 64'b00);
        check_val("br_cdb1_tag", 64'(c1t), 64'd0);
        br = 1'b0;
        fv = '0;
        put(1, 1'b1, 6'h2a, 64'd42, 5'd9);
        put(3, 1'b1, 6'h2b, 64'd43, 5'd10);
        #1;
        check_val("post_br_ack", 64'(ack), 64'b1010);
        tick();
        check_val("post_br_cdb1_tag", 64'(c1t), 64'h2a);
        check_val("post_br_cdb1_rob", 64'(c1r), 64'd9);
        check_val("post_br_cdb2_tag", 64'(c2t), 64'h2b);

        // Asynchronous reset clears a live bus without waiting for an edge
        fv = '0;
        put(0, 1'b1, 6'h3f, 64'd5, 5'd1);
        tick();
        check_val("pre_rst_cdb1_v", 64'(c1v), 64'd1);
        fv = '0;
        reset = 1'b0;
        #1;
        check_val("mid_rst_cdb1_v",   64'(c1v), 64'd0);
        check_val("mid_rst_cdb1_tag", 64'(c1t), 64'd0);
        tick();
        reset = 1'b1;
`else
        // Age priority: head 30, ages FU0=4, FU1=1, FU2=0 -> FU2 then FU1
        fv = '0;
        head = 5'd30;
        put(0, 1'b1, 6'h05, 64'd50, 5'd2);
        put(1, 1'b1, 6'h06, 64'd60, 5'd31);
        put(2, 1'b1, 6'h07, 64'd70, 5'd30);
        #1;
        check_val("age_ack",   64'(ack), 64'b0110);
        check_val("age_avail", 64'(avail), 64'b1110);
        tick();
        check_val("age_cdb1_tag", 64'(c1t), 64'h07);
        check_val("age_cdb2_tag", 64'(c2t), 64'h06);
        check_val("age_cdb1_rob", 64'(c1r), 64'd30);
        put(1, 1'b0, 6'h00, 64'd0, 5'd0);
        put(2, 1'b0, 6'h00, 64'd0, 5'd0);
        #1;
        check_val("age_left_ack", 64'(ack), 64'b0001);
        tick();
        check_val("age_left_cdb1_tag", 64'(c1t), 64'h05);
        check_val("age_left_cdb2_v",   64'(c2v), 64'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
